// File: rtl/riscuva_pkg.sv
// ---------------------------------------------------------------------------
// riscuva_pkg
// Shared definitions for the RISCuva interrupt controller slice:
//   - program address width and default channel-0 vector
//   - opcode constants the core decoder uses to produce ei/di/reti strobes
//   - the per-cycle service action chosen by the controller
// ---------------------------------------------------------------------------
package riscuva_pkg;

    // Program address width (matches the core's progAddress)
    localparam int RV_VEC_W = 10;

    // Vector of channel 0
    localparam logic [RV_VEC_W-1:0] RV_VEC_BASE = 10'h001;

    // Core opcodes that are decoded into the ei / di / reti strobes
    localparam logic [7:0] OPC_EI   = 8'hFB;
    localparam logic [7:0] OPC_DI   = 8'hF3;
    localparam logic [7:0] OPC_RETI = 8'hED;

    // What the service logic does on the coming clock edge.
    // Take and retire are mutually exclusive by construction.
    typedef enum logic [1:0] {
        ACT_IDLE = 2'd0,
        ACT_TAKE = 2'd1,
        ACT_RETI = 2'd2,
        ACT_ERR  = 2'd3
    } vic_act_e;

endpackage

// File: rtl/riscuva_vic_if.sv
// ---------------------------------------------------------------------------
// riscuva_vic_if
// Bundle between the RISCuva core (master) and the interrupt controller
// (slave).
//   core -> vic : irq_in, ei, di, may_irq, reti, mask_wr, mask_data
//   vic -> core : irq_take, irq_vector, irq_id, int_ack, pending,
//                 in_service, err
// ---------------------------------------------------------------------------
interface riscuva_vic_if
    import riscuva_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3,
    parameter int VEC_W = RV_VEC_W
);
    logic [N_IRQ-1:0] irq_in;
    logic             ei;
    logic             di;
    logic             may_irq;
    logic             reti;
    logic             mask_wr;
    logic [N_IRQ-1:0] mask_data;

    logic             irq_take;
    logic [VEC_W-1:0] irq_vector;
    logic [ID_W-1:0]  irq_id;
    logic             int_ack;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] in_service;
    logic             err;

    modport master (
        output irq_in, ei, di, may_irq, reti, mask_wr, mask_data,
        input  irq_take, irq_vector, irq_id, int_ack, pending, in_service, err
    );

    modport slave (
        input  irq_in, ei, di, may_irq, reti, mask_wr, mask_data,
        output irq_take, irq_vector, irq_id, int_ack, pending, in_service, err
    );
endinterface

// File: rtl/riscuva_prio_enc.sv
// ---------------------------------------------------------------------------
// riscuva_prio_enc
// Lowest-set-bit priority encoder (bit 0 = highest priority).
//   i_req   : request vector
//   o_valid : at least one request set
//   o_id    : index of the lowest set request (0 when none)
// ---------------------------------------------------------------------------
module riscuva_prio_enc #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_IRQ-1:0] i_req,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_id = {ID_W{1'b0}};
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            o_id = i_req[i] ? ID_W'(i) : o_id;
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/riscuva_vic.sv
// ---------------------------------------------------------------------------
// riscuva_vic
// Vectored, nested interrupt controller for the RISCuva core family.
// Captures N_IRQ requests (edge or level per channel), masks them, and
// injects the lowest-numbered eligible channel into the core when it can
// accept a call. Nested service is strictly preemptive: while a level is in
// service only lower ids may interrupt it. Interrupted ids are kept on a
// small stack and restored on reti.
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : asynchronous, active-low
//   vic_if : slave side of riscuva_vic_if (requests/strobes in, service
//            status and the one-cycle irq_take/irq_vector out)
// ---------------------------------------------------------------------------
module riscuva_vic
    import riscuva_pkg::*;
#(
    parameter int               N_IRQ      = 8,
    parameter int               ID_W       = 3,
    parameter int               VEC_W      = RV_VEC_W,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(RV_VEC_BASE),
    parameter int               VEC_SHIFT  = 2,
    parameter int               NEST_DEPTH = 4,
    parameter logic [N_IRQ-1:0] EDGE_MODE  = {N_IRQ{1'b1}}
) (
    input logic          clk,
    input logic          reset,
    riscuva_vic_if.slave vic_if
);

    // Depth counts 0..NEST_DEPTH; the stack is sized to the full index range
    // so the depth counter can address it directly.
    localparam int                 DEPTH_W   = $clog2(NEST_DEPTH + 1);
    localparam int                 STACK_N   = 1 << DEPTH_W;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(NEST_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [N_IRQ-1:0]   ONE_HOT0  = {{(N_IRQ-1){1'b0}}, 1'b1};

    logic [N_IRQ-1:0]   r_prev;
    logic [N_IRQ-1:0]   r_pending;
    logic [N_IRQ-1:0]   r_mask;
    logic               r_enable;
    logic [DEPTH_W-1:0] r_depth;
    logic [ID_W-1:0]    r_stack [STACK_N];
    logic [ID_W-1:0]    r_irq_id;
    logic [N_IRQ-1:0]   r_in_service;
    logic               r_irq_take;
    logic [VEC_W-1:0]   r_irq_vector;
    logic               r_int_ack;
    logic               r_err;

    logic [N_IRQ-1:0]   w_rise;
    logic [N_IRQ-1:0]   w_prio_lim;
    logic [N_IRQ-1:0]   w_eligible;
    logic               w_elig_valid;
    logic [ID_W-1:0]    w_win_id;
    logic [N_IRQ-1:0]   w_win_onehot;
    logic [N_IRQ-1:0]   w_cur_onehot;
    logic [N_IRQ-1:0]   w_take_onehot;
    logic [N_IRQ-1:0]   w_pending_nxt;
    logic [VEC_W-1:0]   w_vector;
    logic [DEPTH_W-1:0] w_depth_m1;
    vic_act_e           w_act;

    // While nested, only ids strictly below the serviced one may preempt
    always_comb begin
        w_prio_lim = {N_IRQ{1'b0}};
        for (int i = 0; i < N_IRQ; i++) begin
            w_prio_lim[i] = (r_depth == {DEPTH_W{1'b0}}) || (ID_W'(i) < r_irq_id);
        end
    end

    assign w_eligible = r_pending & r_mask & ~r_in_service & w_prio_lim;

    riscuva_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .i_req   (w_eligible),
        .o_valid (w_elig_valid),
        .o_id    (w_win_id)
    );

    assign w_win_onehot = ONE_HOT0 << w_win_id;
    assign w_cur_onehot = ONE_HOT0 << r_irq_id;
    assign w_vector     = VEC_BASE + (VEC_W'(w_win_id) << VEC_SHIFT);
    assign w_depth_m1   = r_depth - DEPTH_ONE;

    // Choose the service action; reti wins and blocks a take in the same cycle
    always_comb begin
        w_act = ACT_IDLE;
        if (vic_if.reti) begin
            if (r_depth != {DEPTH_W{1'b0}}) begin
                w_act = ACT_RETI;
            end else begin
                w_act = ACT_ERR;
            end
        end else if (w_elig_valid && r_enable && vic_if.may_irq && !r_irq_take
                     && (r_depth < DEPTH_MAX)) begin
            w_act = ACT_TAKE;
        end else begin
            w_act = ACT_IDLE;
        end
    end

    assign w_take_onehot = (w_act == ACT_TAKE) ? w_win_onehot : {N_IRQ{1'b0}};
    assign w_rise        = vic_if.irq_in & ~r_prev;

    // Edge channels: a new edge sets (even in the take cycle), a take clears.
    // Level channels simply follow the registered request line.
    assign w_pending_nxt = (EDGE_MODE & ((r_pending & ~w_take_onehot) | w_rise))
                         | (~EDGE_MODE & vic_if.irq_in);

    // Request capture, mask register and global enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev    <= {N_IRQ{1'b0}};
            r_pending <= {N_IRQ{1'b0}};
            r_mask    <= {N_IRQ{1'b1}};
            r_enable  <= 1'b0;
        end else begin
            r_prev    <= vic_if.irq_in;
            r_pending <= w_pending_nxt;
            if (vic_if.mask_wr) begin
                r_mask <= vic_if.mask_data;
            end else begin
                r_mask <= r_mask;
            end
            // di dominates a simultaneous ei
            if (vic_if.di) begin
                r_enable <= 1'b0;
            end else if (vic_if.ei) begin
                r_enable <= 1'b1;
            end else begin
                r_enable <= r_enable;
            end
        end
    end

    // Service state: take pulse, vector, nesting stack and in-service set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_take   <= 1'b0;
            r_irq_vector <= {VEC_W{1'b0}};
            r_irq_id     <= {ID_W{1'b0}};
            r_int_ack    <= 1'b0;
            r_in_service <= {N_IRQ{1'b0}};
            r_err        <= 1'b0;
            r_depth      <= {DEPTH_W{1'b0}};
            for (int i = 0; i < STACK_N; i++) begin
                r_stack[i] <= {ID_W{1'b0}};
            end
        end else begin
            r_irq_take <= (w_act == ACT_TAKE);
            case (w_act)
                ACT_TAKE: begin
                    // Save the interrupted id (0 when idle) and enter the new one
                    r_irq_vector     <= w_vector;
                    r_stack[r_depth] <= r_irq_id;
                    r_irq_id         <= w_win_id;
                    r_in_service     <= r_in_service | w_win_onehot;
                    r_depth          <= r_depth + DEPTH_ONE;
                    r_int_ack        <= 1'b1;
                end
                ACT_RETI: begin
                    r_in_service <= r_in_service & ~w_cur_onehot;
                    r_irq_id     <= r_stack[w_depth_m1];
                    r_depth      <= w_depth_m1;
                    r_int_ack    <= (r_depth > DEPTH_ONE);
                end
                ACT_ERR: begin
                    r_err <= 1'b1;
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    assign vic_if.irq_take   = r_irq_take;
    assign vic_if.irq_vector = r_irq_vector;
    assign vic_if.irq_id     = r_irq_id;
    assign vic_if.int_ack    = r_int_ack;
    assign vic_if.pending    = r_pending;
    assign vic_if.in_service = r_in_service;
    assign vic_if.err        = r_err;

endmodule

// File: tb/tb_riscuva_vic.sv
// ---------------------------------------------------------------------------
// tb_riscuva_vic
// Scoreboard bench for riscuva_vic (NEST_DEPTH=2, channel 7 level-sensitive).
// The driver steps a behavioural model at every rising edge and queues the
// expected output snapshot; a monitor pops and compares on the falling edge.
// Service nesting is modelled as a queue of ids being serviced.
// ---------------------------------------------------------------------------
module tb_riscuva_vic;

    localparam int         N     = 8;
    localparam int         NEST  = 2;
    localparam logic [7:0] EDGE  = 8'h7F;
    localparam logic [9:0] BASE  = 10'h001;
    localparam int         SHIFT = 2;

    typedef struct {
        logic       take;
        logic [9:0] vec;
        logic [2:0] id;
        logic       ack;
        logic [7:0] pend;
        logic [7:0] insv;
        logic       err;
    } snap_t;

    logic clk;
    logic rst_n;

    riscuva_vic_if #(.N_IRQ(N), .ID_W(3), .VEC_W(10)) bus ();

    riscuva_vic #(
        .N_IRQ      (N),
        .ID_W       (3),
        .VEC_W      (10),
        .VEC_BASE   (BASE),
        .VEC_SHIFT  (SHIFT),
        .NEST_DEPTH (NEST),
        .EDGE_MODE  (EDGE)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .vic_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    snap_t      exp_q[$];
    int         log_id[$];
    int         log_vec[$];

    // Reference model state
    logic [7:0] m_pend, m_mask, m_prev;
    logic       m_en, m_take, m_err;
    logic [9:0] m_vec;
    int         svc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] svc_mask();
        logic [7:0] m;
        m = 8'h00;
        foreach (svc[k]) m[svc[k]] = 1'b1;
        return m;
    endfunction

    function automatic snap_t make_snap();
        snap_t s;
        s.take = m_take;
        s.vec  = m_vec;
        s.ack  = (svc.size() > 0);
        s.id   = (svc.size() > 0) ? 3'(svc[svc.size()-1]) : 3'd0;
        s.pend = m_pend;
        s.insv = svc_mask();
        s.err  = m_err;
        return s;
    endfunction

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'hFF; m_prev = 8'h00;
        m_en = 1'b0; m_take = 1'b0; m_err = 1'b0; m_vec = 10'h000;
        svc.delete();
    endtask

    // One clock edge of the controller, from the behavioural rules
    task automatic model_step();
        int         tid;
        int         cur;
        bit         found;
        bit         took;
        logic [7:0] insv;
        if (!rst_n) begin
            model_reset();
            return;
        end
        insv  = svc_mask();
        cur   = (svc.size() > 0) ? svc[svc.size()-1] : N;
        found = 1'b0;
        tid   = 0;
        for (int i = N - 1; i >= 0; i--)
            if (m_pend[i] && m_mask[i] && !insv[i] && i < cur) begin
                found = 1'b1;
                tid   = i;
            end
        took = 1'b0;
        if (bus.reti) begin
            if (svc.size() == 0) m_err = 1'b1;
            else void'(svc.pop_back());
        end else if (found && m_en && bus.may_irq && !m_take && svc.size() < NEST) begin
            took = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) m_pend[i] = (m_pend[i] && !(took && tid == i)) || (bus.irq_in[i] && !m_prev[i]);
            else         m_pend[i] = bus.irq_in[i];
        end
        m_prev = bus.irq_in;
        m_take = took;
        if (took) begin
            m_vec = 10'(BASE + (tid << SHIFT));
            svc.push_back(tid);
        end
        if (bus.di) m_en = 1'b0;
        else if (bus.ei) m_en = 1'b1;
        if (bus.mask_wr) m_mask = bus.mask_data;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        exp_q.push_back(make_snap());
        #1;
    endtask

    // Asynchronous reset lands before the next falling edge, so the queued
    // expectation for this cycle becomes the reset state.
    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(make_snap());
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        bus.irq_in = m;
        tick();
        bus.irq_in = 8'h00;
        tick();
    endtask

    task automatic do_reti();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("irq_take",   32'(bus.irq_take),   32'(e.take));
            chk("irq_vector", 32'(bus.irq_vector), 32'(e.vec));
            chk("irq_id",     32'(bus.irq_id),     32'(e.id));
            chk("int_ack",    32'(bus.int_ack),    32'(e.ack));
            chk("pending",    32'(bus.pending),    32'(e.pend));
            chk("in_service", 32'(bus.in_service), 32'(e.insv));
            chk("err",        32'(bus.err),        32'(e.err));
            if (bus.irq_take === 1'b1) begin
                log_id.push_back(int'(bus.irq_id));
                log_vec.push_back(int'(bus.irq_vector));
            end
        end
    end

    int exp_ids[13]  = '{3, 2, 5, 1, 6, 4, 2, 0, 3, 4, 3, 1, 7};
    int exp_vecs[13] = '{32'h0D, 32'h09, 32'h15, 32'h05, 32'h19, 32'h11, 32'h09,
                         32'h01, 32'h0D, 32'h11, 32'h0D, 32'h05, 32'h1D};

    initial begin
        rst_n         = 1'b0;
        bus.irq_in    = 8'h00;
        bus.ei        = 1'b0;
        bus.di        = 1'b0;
        bus.may_irq   = 1'b1;
        bus.reti      = 1'b0;
        bus.mask_wr   = 1'b0;
        bus.mask_data = 8'h00;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single edge request: take two edges after the request edge
        bus.ei = 1'b1; tick(); bus.ei = 1'b0;
        pulse_irq(8'h08);
        tick();
        do_reti();
        tick();

        // Simultaneous 5 and 2: 2 first, then 5 right after its reti
        pulse_irq(8'h24);
        do_reti();
        tick();

        // Preemption of 5 by 1; 6 waits until both levels retire
        pulse_irq(8'h02);
        pulse_irq(8'h40);
        tick();
        do_reti();
        tick();
        do_reti();
        tick();
        do_reti();
        tick();

        // Depth limit of 2: 0 waits until a level retires; stray reti sets err
        pulse_irq(8'h10);
        pulse_irq(8'h04);
        pulse_irq(8'h01);
        tick();
        tick();
        do_reti();
        tick();
        bus.reti = 1'b1; tick(); tick(); tick(); bus.reti = 1'b0;
        tick();

        // Masked request stays pending, taken once unmasked
        bus.mask_wr = 1'b1; bus.mask_data = 8'hF7; tick(); bus.mask_wr = 1'b0;
        pulse_irq(8'h08);
        tick();
        bus.mask_wr = 1'b1; bus.mask_data = 8'hFF; tick(); bus.mask_wr = 1'b0;
        tick();
        do_reti();
        tick();

        // di while a request waits blocks it until ei
        bus.irq_in = 8'h10; bus.di = 1'b1; tick();
        bus.irq_in = 8'h00; bus.di = 1'b0; tick();
        tick();
        bus.ei = 1'b1; tick(); bus.ei = 1'b0;
        tick();
        do_reti();
        tick();

        // Reset during nested service; held level channel waits for ei
        pulse_irq(8'h08);
        pulse_irq(8'h02);
        bus.irq_in = 8'h80; tick();
        assert_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        bus.ei = 1'b1; tick(); bus.ei = 1'b0;
        tick();
        bus.irq_in = 8'h00;
        do_reti();
        tick();
        tick();

        @(negedge clk); #1;
        chk("take_count", 32'(log_id.size()), 32'd13);
        for (int i = 0; i < 13 && i < log_id.size(); i++) begin
            chk("take_seq_id",  32'(log_id[i]),  32'(exp_ids[i]));
            chk("take_seq_vec", 32'(log_vec[i]), 32'(exp_vecs[i]));
        end

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            bus.irq_in    = 8'($urandom) & 8'($urandom) & 8'($urandom);
            bus.ei        = ($urandom_range(0, 7) == 0);
            bus.di        = ($urandom_range(0, 15) == 0);
            bus.reti      = ($urandom_range(0, 5) == 0);
            bus.may_irq   = ($urandom_range(0, 3) != 0);
            bus.mask_wr   = ($urandom_range(0, 31) == 0);
            bus.mask_data = 8'($urandom);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) assert_reset();
            tick();
        end

        bus.reti = 1'b0; bus.irq_in = 8'h00;
        tick();
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
